// File: rtl/down_counter.sv
// -----------------------------------------------------------------------------
// down_counter
//
// Loadable, pausable down-counter/timer. A start value is loaded, `start`
// launches the count, and the block decrements once per clock until it reaches
// zero, where it raises a one-cycle terminal-count pulse (tc).
//
// Configuration macro:
//   DOWN_COUNTER_AUTO_RELOAD_EN - when defined, reaching the terminal edge
//     reloads the count from the reload register and keeps running (periodic
//     tc). When undefined, the counter stops at zero and returns to IDLE.
//
// Ports:
//   clk      in   system clock, rising-edge active
//   clr      in   asynchronous active-high reset
//   load     in   load strobe; samples load_val (any state, aborts a count)
//   load_val in   [WIDTH-1:0] value to count down from
//   start    in   begin counting (honoured in IDLE only)
//   stop     in   abort counting, q holds (honoured in RUN only)
//   hold     in   freeze the count while in RUN
//   q        out  [WIDTH-1:0] current count, registered
//   busy     out  high while in RUN, registered state
//   tc       out  terminal-count pulse, registered, one cycle wide
//
// Control strobes: every strobe is a single-cycle level sampled on the rising
// clock edge; there is no handshake back-pressure. Priority at an edge is
// load > stop > start/hold > decrement.
// -----------------------------------------------------------------------------
module down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             tc
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q,     tc_d;

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            count_q  <= ZERO;
            reload_q <= ZERO;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            state_d  = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        // A zero-length count finishes immediately: pulse tc
                        // without ever entering RUN.
                        if (count_q != ZERO) begin
                            state_d = RUN;
                        end else begin
                            tc_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = IDLE;
                    end else if (hold) begin
                        state_d = RUN;
                    end else if (count_q > ONE) begin
                        count_d = count_q - ONE;
                    end else if (count_q == ONE) begin
                        tc_d = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                        count_d = reload_q;
                        state_d = RUN;
`else
                        count_d = ZERO;
                        state_d = IDLE;
`endif
                    end else begin
                        // RUN is only entered with a nonzero count; if zero is
                        // ever seen here, drop to IDLE rather than wrap.
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign q    = count_q;
    assign busy = (state_q == RUN);
    assign tc   = tc_q;

endmodule

// File: tb/tb_down_counter.sv
module tb_down_counter;

  localparam int W = 4;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic         clk;
  logic         clr;
  logic         load;
  logic [W-1:0] load_val;
  logic         start;
  logic         stop;
  logic         hold;
  logic [W-1:0] q;
  logic         busy;
  logic         tc;

  // expected {q, busy, tc} after the next edge
  logic [W+1:0] exp_q[$];
  int           checks;
  int           errors;

  down_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .hold     (hold),
    .q        (q),
    .busy     (busy),
    .tc       (tc)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of inputs, pushes the expected post-edge outputs, then
  // pops and compares after the edge.
  task automatic drive_cycle(input string tag, input logic l, input logic [W-1:0] lv,
                             input logic s, input logic sp, input logic h,
                             input logic [W-1:0] eq, input logic eb, input logic et);
    logic [W+1:0] e;
    load     = l;
    load_val = lv;
    start    = s;
    stop     = sp;
    hold     = h;
    exp_q.push_back({eq, eb, et});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val({tag, ".q"},    32'(q),    32'(e[W+1:2]));
    check_val({tag, ".busy"}, 32'(busy), 32'(e[1]));
    check_val({tag, ".tc"},   32'(tc),   32'(e[0]));
  endtask

  task automatic idle_cyc(input string tag, input logic [W-1:0] eq, input logic eb);
    drive_cycle(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0, eq, eb, 1'b0);
  endtask

  // Terminal edge followed by a stop; covers both build variants.
  task automatic terminal(input string tag, input logic [W-1:0] v);
    drive_cycle({tag, ".term"}, 1'b0, '0, 1'b0, 1'b0, 1'b0, AR ? v : '0, AR, 1'b1);
    drive_cycle({tag, ".post"}, 1'b0, '0, 1'b0, 1'b1, 1'b0, AR ? v : '0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] v;
    checks = 0;
    errors = 0;
    clr = 1'b0; load = 1'b0; load_val = '0; start = 1'b0; stop = 1'b0; hold = 1'b0;
    #1 clr = 1'b1;
    #1;
    check_val("rst.q", 32'(q), 0);
    check_val("rst.busy", 32'(busy), 0);
    check_val("rst.tc", 32'(tc), 0);
    @(posedge clk);
    #1 clr = 1'b0;

    // basic count from 5
    drive_cycle("basic.load", 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0);
    drive_cycle("basic.start", 1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0);
    for (int i = 4; i >= 1; i--) idle_cyc("basic.dec", W'(i), 1'b1);
    terminal("basic", 4'd5);

    // hold for 3 cycles at q=4
    drive_cycle("hold.load", 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 4'd6, 1'b0, 1'b0);
    drive_cycle("hold.start", 1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0);
    idle_cyc("hold.dec5", 4'd5, 1'b1);
    idle_cyc("hold.dec4", 4'd4, 1'b1);
    for (int i = 0; i < 3; i++)
      drive_cycle("hold.frz", 1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0);
    for (int i = 3; i >= 1; i--) idle_cyc("hold.dec", W'(i), 1'b1);
    terminal("hold", 4'd6);

    // stop at q=3, then stop/hold in IDLE are ignored
    drive_cycle("stop.load", 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 4'd6, 1'b0, 1'b0);
    drive_cycle("stop.start", 1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0);
    for (int i = 5; i >= 3; i--) idle_cyc("stop.dec", W'(i), 1'b1);
    drive_cycle("stop.stop", 1'b0, '0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0);
    idle_cyc("stop.idle", 4'd3, 1'b0);
    drive_cycle("stop.idle_stop", 1'b0, '0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0);
    drive_cycle("stop.idle_hold", 1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0);

    // zero-length count
    drive_cycle("zero.load", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    drive_cycle("zero.start", 1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    idle_cyc("zero.after", 4'd0, 1'b0);
    idle_cyc("zero.after2", 4'd0, 1'b0);

    // max count, no wrap
    drive_cycle("max.load", 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 4'd15, 1'b0, 1'b0);
    drive_cycle("max.start", 1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd15, 1'b1, 1'b0);
    for (int i = 14; i >= 1; i--) idle_cyc("max.dec", W'(i), 1'b1);
    terminal("max", 4'd15);
    if (!AR) begin
      for (int i = 0; i < 3; i++) idle_cyc("max.nowrap", 4'd0, 1'b0);
    end

    // priority: load+start, load during RUN, start in RUN, stop+hold
    drive_cycle("prio.ldst", 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0);
    idle_cyc("prio.idle", 4'd7, 1'b0);
    drive_cycle("prio.start", 1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0);
    for (int i = 6; i >= 2; i--) idle_cyc("prio.dec", W'(i), 1'b1);
    drive_cycle("prio.ldrun", 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0);
    idle_cyc("prio.ldidle", 4'd3, 1'b0);
    drive_cycle("prio.start2", 1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0);
    drive_cycle("prio.strun", 1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0);
    drive_cycle("prio.stophold", 1'b0, '0, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0);

    // auto-reload behaviour (single tc without the feature)
    drive_cycle("ar.load", 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0);
    drive_cycle("ar.start", 1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0);
    idle_cyc("ar.d2", 4'd2, 1'b1);
    idle_cyc("ar.d1", 4'd1, 1'b1);
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    for (int r = 0; r < 2; r++) begin
      drive_cycle("ar.reload", 1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b1);
      idle_cyc("ar.d2", 4'd2, 1'b1);
      idle_cyc("ar.d1", 4'd1, 1'b1);
    end
    drive_cycle("ar.reload", 1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b1);
    drive_cycle("ar.stop", 1'b0, '0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0);
    drive_cycle("ar1.load", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0);
    drive_cycle("ar1.start", 1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      drive_cycle("ar1.tc", 1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b1);
    drive_cycle("ar1.stop", 1'b0, '0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
`else
    drive_cycle("ar.term", 1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) idle_cyc("ar.single", 4'd0, 1'b0);
    drive_cycle("ar1.load", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0);
    drive_cycle("ar1.start", 1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0);
    drive_cycle("ar1.term", 1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    idle_cyc("ar1.after", 4'd0, 1'b0);
`endif

    // random-length counts from random load values
    for (int t = 0; t < 4; t++) begin
      v = W'($urandom_range(2, 15));
      drive_cycle("rnd.load", 1'b1, v, 1'b0, 1'b0, 1'b0, v, 1'b0, 1'b0);
      drive_cycle("rnd.start", 1'b0, '0, 1'b1, 1'b0, 1'b0, v, 1'b1, 1'b0);
      for (int i = int'(v) - 1; i >= 1; i--) idle_cyc("rnd.dec", W'(i), 1'b1);
      terminal("rnd", v);
    end

    // asynchronous reset mid-count
    drive_cycle("mid.load", 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0);
    drive_cycle("mid.start", 1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd9, 1'b1, 1'b0);
    for (int i = 8; i >= 6; i--) idle_cyc("mid.dec", W'(i), 1'b1);
    #3 clr = 1'b1;
    #1;
    check_val("mid.rst.q", 32'(q), 0);
    check_val("mid.rst.busy", 32'(busy), 0);
    check_val("mid.rst.tc", 32'(tc), 0);
    #2 clr = 1'b0;
    idle_cyc("mid.after", 4'd0, 1'b0);
    idle_cyc("mid.after2", 4'd0, 1'b0);

    check_val("sb.empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
